// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: merges the core's instruction and data SRAM-like ports
// onto one AXI3 master. Reads share a single read channel (data has
// priority over fetch); data writes run on the write channels and may
// overlap an instruction read. At most one read and one write in flight.
//
// read state | meaning
// R_IDLE     | no read in flight, grants allowed
// R_AR       | arvalid high, waiting for arready
// R_R        | rready high, waiting for rvalid
//
// write state | meaning
// W_IDLE      | no write in flight, data writes may be accepted
// W_AW        | awvalid/wvalid raised, each drops on its own ready
// W_B         | both handshakes done, bready high until bvalid
module sram_axi_bridge (
  input  logic        clk,
  input  logic        reset,
  // instruction SRAM-like port
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data SRAM-like port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_B} w_state_t;

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;

  logic        rd_owner;  // 1 = data side owns the read in flight
  logic [31:0] rd_addr;
  logic [2:0]  rd_size;
  logic [31:0] wr_addr;
  logic [2:0]  wr_size;
  logic [3:0]  wr_strb;
  logic [31:0] wr_data;
  logic        aw_done;
  logic        w_done;

  logic data_rd_grant;
  logic inst_rd_grant;
  logic data_wr_grant;
  logic data_rd_busy;
  logic aw_fin;
  logic w_fin;

  // Fixed AXI fields: single-beat incrementing bursts, no locking/caching.
  assign arid    = 4'd0;
  assign arlen   = 4'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awid    = 4'd0;
  assign awlen   = 4'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = 4'd0;
  assign wlast   = 1'b1;

  // Request arbitration; data reads wait for an idle write side so that
  // only one data-side transaction is ever outstanding.
  always_comb begin
    data_rd_busy  = (r_state != R_IDLE) && rd_owner;
    data_rd_grant = !reset && (r_state == R_IDLE) && data_req && !data_wr
                    && (w_state == W_IDLE);
    inst_rd_grant = !reset && (r_state == R_IDLE) && !data_rd_grant && inst_req;
    data_wr_grant = !reset && (w_state == W_IDLE) && data_req && data_wr
                    && !data_rd_busy;
  end

  // Read FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  // Read FSM next-state logic.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: if (data_rd_grant || inst_rd_grant) r_next = R_AR;
      R_AR:   if (arready) r_next = R_R;
      R_R:    if (rvalid) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read FSM outputs and read-side response steering.
  always_comb begin
    arvalid      = (r_state == R_AR);
    rready       = (r_state == R_R);
    araddr       = rd_addr;
    arsize       = rd_size;
    inst_addr_ok = inst_rd_grant;
    inst_data_ok = rvalid && rready && !rd_owner;
    inst_rdata   = rdata;
    data_rdata   = rdata;
  end

  // Latch read address, size and owner on the grant edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_owner <= 1'b0;
      rd_addr  <= 32'd0;
      rd_size  <= 3'd0;
    end else if (data_rd_grant) begin
      rd_owner <= 1'b1;
      rd_addr  <= data_addr;
      rd_size  <= {1'b0, data_size};
    end else if (inst_rd_grant) begin
      rd_owner <= 1'b0;
      rd_addr  <= inst_addr;
      rd_size  <= 3'd2;
    end
  end

  // Write FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_next;
  end

  // Write FSM next-state logic; AW and W complete independently.
  always_comb begin
    w_next = w_state;
    aw_fin = aw_done || awready;
    w_fin  = w_done || wready;
    case (w_state)
      W_IDLE: if (data_wr_grant) w_next = W_AW;
      W_AW:   if (aw_fin && w_fin) w_next = W_B;
      W_B:    if (bvalid) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Write FSM outputs and combined data-side completion.
  always_comb begin
    awvalid      = (w_state == W_AW) && !aw_done;
    wvalid       = (w_state == W_AW) && !w_done;
    bready       = (w_state == W_B);
    awaddr       = wr_addr;
    awsize       = wr_size;
    wdata        = wr_data;
    wstrb        = wr_strb;
    data_addr_ok = data_rd_grant || data_wr_grant;
    data_data_ok = (rvalid && rready && rd_owner) || (bvalid && bready);
  end

  // Track which of the two write-request handshakes has completed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (w_state != W_AW) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (awvalid && awready) aw_done <= 1'b1;
      if (wvalid && wready)   w_done  <= 1'b1;
    end
  end

  // Latch the write payload on acceptance; held stable until handshakes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr <= 32'd0;
      wr_size <= 3'd0;
      wr_strb <= 4'd0;
      wr_data <= 32'd0;
    end else if (data_wr_grant) begin
      wr_addr <= data_addr;
      wr_size <= {1'b0, data_size};
      wr_strb <= data_wstrb;
      wr_data <= data_wdata;
    end
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb_sram_axi_bridge: directed scenarios with a response scoreboard. A
// background read slave answers AR requests; the write side is driven
// per scenario so handshake timing can be shaped exactly.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, data_req, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid;
  logic [1:0]  arburst, arlock, awburst, awlock;
  logic [2:0]  arprot, awprot, arsize, awsize;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [3:0]  wstrb;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          is_wr;
    logic [31:0] d;
  } resp_t;

  logic [31:0] inst_q[$];
  resp_t       data_q[$];

  int          r_lat = 0;
  bit          rd_pend = 0;
  int          r_cnt = 0;
  logic [31:0] rd_a = 0;

  sram_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
    .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  // Memory contents seen by the read slave.
  function automatic logic [31:0] rmem(input logic [31:0] a);
    return (a == 32'h1c00_0000) ? 32'h0280_0401 : (a ^ 32'hdead_beef);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic wait_ok(input string tag, input bit is_data, input int max);
    bit hit = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (is_data ? data_data_ok : inst_data_ok) begin
        hit = 1;
        break;
      end
    end
    chk(tag, {31'd0, hit}, 32'd1);
  endtask

  // Read slave: AR handshake seen at negedge, rvalid raised r_lat cycles later.
  initial begin
    logic        nxt_rvalid;
    logic [31:0] nxt_rdata;
    arready = 1'b1;
    rvalid  = 1'b0;
    rdata   = 32'd0;
    forever begin
      @(negedge clk);
      nxt_rvalid = rvalid;
      nxt_rdata  = rdata;
      if (reset) begin
        rd_pend    = 0;
        nxt_rvalid = 1'b0;
      end else begin
        if (rvalid && rready) nxt_rvalid = 1'b0;
        if (arvalid && arready) begin
          rd_pend = 1;
          r_cnt   = r_lat;
          rd_a    = araddr;
        end else if (rd_pend && r_cnt > 0) begin
          r_cnt--;
        end
        if (rd_pend && r_cnt == 0) begin
          nxt_rvalid = 1'b1;
          nxt_rdata  = rmem(rd_a);
          rd_pend    = 0;
        end
      end
      @(posedge clk);
      #1;
      rvalid = nxt_rvalid;
      rdata  = nxt_rdata;
    end
  end

  // Scoreboard: push on acceptance, pop and compare on completion.
  always @(negedge clk) begin
    resp_t e;
    if (reset) begin
      chk("ok_in_reset", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    end else begin
      if (inst_data_ok) begin
        if (inst_q.size() == 0) chk("inst_ok_unexpected", 32'd1, 32'd0);
        else chk("inst_rdata", inst_rdata, inst_q.pop_front());
      end
      if (data_data_ok) begin
        if (data_q.size() == 0) chk("data_ok_unexpected", 32'd1, 32'd0);
        else begin
          e = data_q.pop_front();
          if (e.is_wr) chk("wr_done_on_bvalid", {31'd0, bvalid}, 32'd1);
          else         chk("data_rdata", data_rdata, e.d);
        end
      end
      if (inst_req && inst_addr_ok) inst_q.push_back(rmem(inst_addr));
      if (data_req && data_addr_ok) data_q.push_back('{is_wr: data_wr, d: rmem(data_addr)});
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit early, done;
    reset = 1'b1;
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b0;
    inst_addr = 32'h1c00_0000; data_addr = 32'h8000_0000;
    data_size = 2'd2; data_wstrb = 4'hf; data_wdata = 32'd0;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0;

    // Reset state, with requests held high to check addr_ok gating.
    repeat (2) @(negedge clk);
    chk("rst_valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
    chk("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    chk("rst_regs_addr", araddr | awaddr, 32'd0);
    chk("rst_regs_data", {wdata[27:0], wstrb} | {26'd0, arsize, awsize}, 32'd0);
    @(posedge clk); #1;
    inst_req = 1'b0; data_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Minimum-latency instruction fetch.
    #1;
    inst_req = 1'b1; inst_addr = 32'h1c00_0000;
    @(negedge clk);
    chk("t1_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    @(posedge clk); #1;
    inst_req = 1'b0;
    @(negedge clk);
    chk("t1_arvalid", {31'd0, arvalid}, 32'd1);
    chk("t1_araddr", araddr, 32'h1c00_0000);
    chk("t1_arsize", {29'd0, arsize}, 32'd2);
    @(negedge clk);
    chk("t1_inst_data_ok_c2", {31'd0, inst_data_ok}, 32'd1);
    repeat (2) @(posedge clk);

    // Simultaneous inst and data reads: data first.
    #1;
    inst_req = 1'b1; inst_addr = 32'h1c00_0004;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd1; data_addr = 32'h8000_1002;
    @(negedge clk);
    chk("t2_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    chk("t2_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    chk("t2_arsize_next", {30'd0, data_size}, 32'd1);
    @(posedge clk); #1;
    data_req = 1'b0;
    early = 0; done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (inst_addr_ok) early = 1;
      if (data_data_ok) begin done = 1; break; end
    end
    chk("t2_data_done", {31'd0, done}, 32'd1);
    chk("t2_inst_held", {31'd0, early}, 32'd0);
    @(negedge clk);
    chk("t2_inst_after", {31'd0, inst_addr_ok}, 32'd1);
    @(posedge clk); #1;
    inst_req = 1'b0;
    wait_ok("t2_inst_done", 1'b0, 10);
    repeat (2) @(posedge clk);

    // Byte store with awready delayed.
    #1;
    awready = 1'b0; wready = 1'b1;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_wstrb = 4'b1000;
    data_addr = 32'h8000_0003; data_wdata = 32'hAB00_0000;
    @(negedge clk);
    chk("t3_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    @(posedge clk); #1;
    data_req = 1'b0;
    @(negedge clk);
    chk("t3_c1_valids", {30'd0, awvalid, wvalid}, 32'd3);
    chk("t3_awaddr", awaddr, 32'h8000_0003);
    chk("t3_wdata", wdata, 32'hAB00_0000);
    chk("t3_wstrb_size", {25'd0, wstrb, awsize}, {25'd0, 4'b1000, 3'd0});
    @(negedge clk);
    chk("t3_c2_valids", {30'd0, awvalid, wvalid}, 32'd2);
    @(posedge clk); #1;
    awready = 1'b1;
    @(negedge clk);
    chk("t3_c3_aw_bready", {30'd0, awvalid, bready}, 32'd2);
    @(posedge clk); #1;
    awready = 1'b0;
    @(negedge clk);
    chk("t3_c4_aw_bready", {29'd0, awvalid, bready, data_data_ok}, 32'd2);
    @(posedge clk); #1;
    bvalid = 1'b1;
    @(negedge clk);
    chk("t3_data_ok", {31'd0, data_data_ok}, 32'd1);
    @(posedge clk); #1;
    bvalid = 1'b0; awready = 1'b1;
    @(negedge clk);
    chk("t3_bready_low", {31'd0, bready}, 32'd0);

    // Write outstanding: data read blocked, inst read proceeds.
    @(posedge clk); #1;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hf;
    data_addr = 32'h8000_0100; data_wdata = 32'h1122_3344;
    @(negedge clk);
    chk("t4_wr_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    @(posedge clk); #1;
    data_req = 1'b0;
    @(posedge clk); #1;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_0200;
    inst_req = 1'b1; inst_addr = 32'h1c00_0010;
    @(negedge clk);
    chk("t4_bready", {31'd0, bready}, 32'd1);
    chk("t4_addr_oks", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
    @(posedge clk); #1;
    inst_req = 1'b0;
    early = 0; done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (data_addr_ok) early = 1;
      if (inst_data_ok) done = 1;
    end
    chk("t4_data_rd_blocked", {31'd0, early}, 32'd0);
    chk("t4_inst_completed", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    bvalid = 1'b1;
    @(negedge clk);
    chk("t4_wr_done", {30'd0, data_data_ok, data_addr_ok}, 32'd2);
    @(posedge clk); #1;
    bvalid = 1'b0;
    @(negedge clk);
    chk("t4_rd_granted", {31'd0, data_addr_ok}, 32'd1);
    @(posedge clk); #1;
    data_req = 1'b0;
    wait_ok("t4_rd_done", 1'b1, 10);
    repeat (2) @(posedge clk);

    // Reset during R_R with a data read pending.
    #1;
    r_lat = 100;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_0300;
    @(negedge clk);
    chk("t5_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    @(posedge clk); #1;
    data_req = 1'b0;
    @(negedge clk);
    chk("t5_arvalid", {31'd0, arvalid}, 32'd1);
    @(negedge clk);
    chk("t5_rready", {31'd0, rready}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rst_immediate", {29'd0, rready, arvalid, data_data_ok}, 32'd0);
    data_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; r_lat = 0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = 32'h1c00_0020;
    @(negedge clk);
    chk("t5_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    @(posedge clk); #1;
    inst_req = 1'b0;
    wait_ok("t5_inst_done", 1'b0, 10);
    repeat (3) @(negedge clk);

    chk("inst_q_empty", inst_q.size(), 32'd0);
    chk("data_q_empty", data_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_axi_bridge.md
# sram_axi_bridge
Converts the core's instruction and data SRAM-like request/response ports into one AXI3 master port, sitting directly downstream of `mycpu_top` between the core and the memory system. Reads from both sides share one read channel with data priority; data writes use the write channels concurrently with instruction reads. At most one read and one write are in flight at any time.
## Interface
- No parameters. The top level ties the remaining fields: arid/awid/wid=0, arlen/awlen=0, arburst/awburst=2'b01, lock/cache/prot=0, wlast=1. rresp/bresp are ignored.
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- inst_req  in  1  instruction read request; always word-size
- inst_addr  in  32  fetch address
- inst_addr_ok  out  1  request accepted this cycle
- inst_data_ok  out  1  read data valid this cycle
- inst_rdata  out  32  fetch data, valid with inst_data_ok
- data_req  in  1  data request
- data_wr  in  1  1=write, 0=read
- data_size  in  2  0=byte, 1=half, 2=word
- data_wstrb  in  4  write byte strobes
- data_addr  in  32  data address
- data_wdata  in  32  write data
- data_addr_ok  out  1  request accepted this cycle
- data_data_ok  out  1  read data valid / write completed this cycle
- data_rdata  out  32  load data, valid with data_data_ok on reads
- araddr  out  32  AXI read address
- arsize  out  3  {1'b0,size}; 3'd2 for instruction fetches
- arvalid  out  1  read address valid
- arready  in  1  read address ready
- rdata  in  32  AXI read data
- rvalid  in  1  read data valid
- rready  out  1  read data ready
- awaddr  out  32  write address
- awsize  out  3  {1'b0,data_size}
- awvalid  out  1  write address valid
- awready  in  1  write address ready
- wdata  out  32  write data
- wstrb  out  4  write strobes
- wvalid  out  1  write data valid
- wready  in  1  write data ready
- bvalid  in  1  write response valid
- bready  out  1  write response ready
## Operation
- Read FSM: R_IDLE -> R_AR (arvalid=1, address/size/owner latched) -> on arready R_R (rready=1) -> on rvalid R_IDLE. The owner bit records inst or data.
- Grant in R_IDLE: a data read is granted when data_req&~data_wr and write FSM is W_IDLE. Otherwise an inst read is granted when inst_req is high. Data has priority when both are eligible.
- Write FSM: W_IDLE -> W_AW (awvalid and wvalid raised together; each drops independently on its own ready) -> when both handshakes are done, W_B (bready=1) -> on bvalid W_IDLE.
- A data write is accepted only when write FSM is W_IDLE and no data read is in flight (read FSM not idle with owner=data). This gives one outstanding data-side transaction, so data responses never collide and there is no RAW hazard.
- addr_ok is combinational: it is high in the cycle req is granted; the request is latched on that edge.
- inst_data_ok = rvalid&rready&owner==inst. data_data_ok = (rvalid&rready&owner==data) | (bvalid&bready). rdata passes through to the owner's *_rdata.
- Instruction reads and data writes may overlap freely.
## Timing
- Reset: both FSMs idle. arvalid, rready, awvalid, wvalid, bready, addr_ok and data_ok are all 0. Latched address, size, strobe and data registers are 0.
- Reset is asynchronous: asserting it mid-transaction drops all valids and readies in the same cycle, and any in-flight transaction is abandoned.
- Minimum read: req/addr_ok in cycle 0, arvalid in cycle 1. If arready=1 in cycle 1, rready is high from cycle 2, and rvalid in cycle 2 gives data_ok in cycle 2.
- Minimum write: addr_ok in cycle 0, awvalid and wvalid in cycle 1. With both readies in cycle 1, bready is high from cycle 2, and bvalid in cycle 2 gives data_data_ok in cycle 2.
- Once raised, arvalid, awvalid and wvalid stay high with stable payload until their own ready is seen. No new read is granted in the cycle the read FSM returns to idle; grants resume the following cycle.
## Test plan
- Inst read at 0x1c000000, arready=1, rvalid one cycle later with rdata=0x02800401. Required: inst_addr_ok in cycle 0, araddr=0x1c000000 and arsize=2 in cycle 1, inst_data_ok with inst_rdata=0x02800401 in cycle 2.
- Inst and data reads requested in the same cycle. Required: data_addr_ok=1 and inst_addr_ok=0. The inst read is issued only after data_data_ok.
- Byte store: addr 0x80000003, wstrb=4'b1000, wdata=0xAB000000, with awready delayed 3 cycles and wready=1. Required: wvalid drops after 1 cycle, awvalid is held 3 cycles, then bready, then data_data_ok on bvalid.
- Write outstanding, then a data read requested. Required: data_addr_ok stays 0 until bvalid. A concurrent inst read proceeds and completes while the write is pending.
- Reset asserted during R_R with a data read pending. Required: rready and arvalid are 0 immediately and no data_ok is produced. After reset release, a fresh inst read completes normally.
